// File: rtl/pearson_pkg.sv
// Shared definitions for the Pearson hash block: table geometry, FSM states
// and the permutation-table read helper.
package pearson_pkg;

  localparam int TABLE_ENTRIES = 256;
  localparam int TABLE_BITS    = 8 * TABLE_ENTRIES;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Entry k occupies bits [8k+7:8k]; the 11-bit offset covers all 2048 bits.
  function automatic logic [7:0] table_lookup(input logic [TABLE_BITS-1:0] tbl,
                                              input logic [7:0]            idx8);
    return tbl[{idx8, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pearson_lane.sv
// One combinational Pearson step for a single lane: seed lookup on the first
// byte, chained lookup on every later byte.
module pearson_lane
  import pearson_pkg::*;
(
  input  logic                  is_first,
  input  logic [7:0]            lane_id,
  input  logic [7:0]            msg_byte,
  input  logic [7:0]            prev_h,
  input  logic [TABLE_BITS-1:0] table_flat,
  output logic [7:0]            next_h
);

  logic [7:0] addr;

  // The seed index wraps modulo 256, so lane 1 with byte 0xFF reads entry 0.
  assign addr   = is_first ? (msg_byte + lane_id) : (prev_h ^ msg_byte);
  assign next_h = table_lookup(table_flat, addr);

endmodule

// File: rtl/pearson_hash_stream.sv
// Multi-lane Pearson hasher: latches a message, hashes one byte per cycle
// across all lanes, then holds the result until the consumer takes it.
module pearson_hash_stream
  import pearson_pkg::*;
#(
  parameter int MSG_BYTES  = 4,
  parameter int HASH_BYTES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*MSG_BYTES-1:0]  message,
  input  logic [TABLE_BITS-1:0]   table_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*HASH_BYTES-1:0] hash,
  output logic                    busy
);

  localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [8*MSG_BYTES-1:0]         msg_reg;
  logic [HASH_BYTES-1:0][7:0]     lane_h;
  logic [HASH_BYTES-1:0][7:0]     lane_next;
  logic                           is_first;

  assign is_first = (idx == '0);

  for (genvar j = 0; j < HASH_BYTES; j++) begin : g_lane
    pearson_lane u_lane (
      .is_first  (is_first),
      .lane_id   (8'(j)),
      .msg_byte  (msg_reg[7:0]),
      .prev_h    (lane_h[j]),
      .table_flat(table_flat),
      .next_h    (lane_next[j])
    );
  end

  // The message register shifts right each RUN cycle so the current byte is
  // always in the low 8 bits; it carries data only and needs no reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == IDLE && in_valid) begin
        msg_reg <= message;
      end else if (state == RUN) begin
        msg_reg <= msg_reg >> 8;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      lane_h    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            idx      <= '0;
          end
        end
        RUN: begin
          lane_h <= lane_next;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here, even alongside out_ready.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            idx       <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

  // Lane values are only visible while the result is being offered.
  assign hash = out_valid ? lane_h : '0;

endmodule
